// File: rtl/fir_coeff_seq_if.sv
// Command and coefficient-write bundle between a controller (master) and fir_coeff_seq (slave).
// Widths follow the channel count, tap count and coefficient width of the attached sequencer.
interface fir_coeff_seq_if #(
    parameter int NCH   = 4,
    parameter int NTAPS = 16,
    parameter int DW    = 16
);
    localparam int AW  = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic           we_in;
    logic [3:0]     opcode;
    logic [CHW-1:0] ch_in;
    logic [DW-1:0]  din;

    logic           c_sto;
    logic           c_clr;
    logic [AW-1:0]  c_addr;
    logic [DW-1:0]  c_data;
    logic [NCH-1:0] c_ch;
    logic [NCH-1:0] run_en;
    logic           busy;
    logic           cmd_err;

    modport master (
        output we_in, opcode, ch_in, din,
        input  c_sto, c_clr, c_addr, c_data, c_ch, run_en, busy, cmd_err
    );

    modport slave (
        input  we_in, opcode, ch_in, din,
        output c_sto, c_clr, c_addr, c_data, c_ch, run_en, busy, cmd_err
    );
endinterface

// File: rtl/fir_coeff_seq.sv
// Per-channel FIR coefficient sequencer: one command at a time, strobes appear two cycles after we_in.
// No stalling: a we_in arriving while busy is dropped and answered with a one-cycle cmd_err.
module fir_coeff_seq #(
    parameter int NCH   = 4,
    parameter int NTAPS = 16,
    parameter int DW    = 16
) (
    input  logic           clk,
    input  logic           rst,
    fir_coeff_seq_if.slave bus
);
    localparam int AW  = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [3:0] OP_STOP    = 4'b0000;
    localparam logic [3:0] OP_START   = 4'b0001;
    localparam logic [3:0] OP_RST_PTR = 4'b0010;
    localparam logic [3:0] OP_SET     = 4'b0100;
    localparam logic [3:0] OP_CLR_ALL = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_STO,
        ST_CLR
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     op_q;
    logic [CHW-1:0] ch_q;
    logic [DW-1:0]  din_q;
    logic [AW-1:0]  ptr_q [NCH];
    logic [AW-1:0]  ptr_d [NCH];
    logic [NCH-1:0] run_en_q, run_en_d;
    logic [AW-1:0]  clr_cnt_q, clr_cnt_d;
    logic           cmd_err_q, cmd_err_d;

    logic           cap_en;
    logic           op_ok;
    logic           ch_ok;
    logic           last_clr;
    logic [AW-1:0]  ptr_next;
    logic [NCH-1:0] ch_onehot;

    logic [AW-1:0]  c_addr_w;
    logic [DW-1:0]  c_data_w;
    logic [NCH-1:0] c_ch_w;

    always_comb begin
        op_ok = 1'b0;
        case (op_q)
            OP_STOP, OP_START, OP_RST_PTR, OP_SET, OP_CLR_ALL: op_ok = 1'b1;
            default: op_ok = 1'b0;
        endcase
    end

    // CHW can encode more codes than there are channels when NCH is not a power of two.
    assign ch_ok    = (int'(ch_q) < NCH);
    assign last_clr = (clr_cnt_q == AW'(NTAPS - 1));
    assign ptr_next = (ptr_q[ch_q] == AW'(NTAPS - 1)) ? '0 : ptr_q[ch_q] + 1'b1;

    always_comb begin
        ch_onehot       = '0;
        ch_onehot[ch_q] = 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        run_en_d  = run_en_q;
        clr_cnt_d = clr_cnt_q;
        cmd_err_d = 1'b0;
        cap_en    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.we_in) begin
                    cap_en  = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = ST_IDLE;
                if (!op_ok || !ch_ok) begin
                    cmd_err_d = 1'b1;
                end else begin
                    case (op_q)
                        OP_STOP:    run_en_d[ch_q] = 1'b0;
                        OP_START:   run_en_d[ch_q] = 1'b1;
                        OP_RST_PTR: ptr_d[ch_q]    = '0;
                        OP_SET:     state_d        = ST_STO;
                        OP_CLR_ALL: begin
                            state_d   = ST_CLR;
                            clr_cnt_d = '0;
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
            ST_STO: begin
                ptr_d[ch_q] = ptr_next;
                state_d     = ST_IDLE;
            end
            ST_CLR: begin
                if (last_clr) begin
                    ptr_d[ch_q] = '0;
                    clr_cnt_d   = '0;
                    state_d     = ST_IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Dropped command: the FSM keeps going, only the error pulse reports it.
        if (state_q != ST_IDLE && bus.we_in) begin
            cmd_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            run_en_q  <= '0;
            clr_cnt_q <= '0;
            cmd_err_q <= 1'b0;
            op_q      <= '0;
            ch_q      <= '0;
            din_q     <= '0;
            for (int i = 0; i < NCH; i++) begin
                ptr_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            run_en_q  <= run_en_d;
            clr_cnt_q <= clr_cnt_d;
            cmd_err_q <= cmd_err_d;
            ptr_q     <= ptr_d;
            if (cap_en) begin
                op_q  <= bus.opcode;
                ch_q  <= bus.ch_in;
                din_q <= bus.din;
            end
        end
    end

    // Address/data/channel are forced to zero outside a strobe cycle.
    always_comb begin
        c_addr_w = '0;
        c_data_w = '0;
        c_ch_w   = '0;
        if (state_q == ST_STO) begin
            c_addr_w = ptr_q[ch_q];
            c_data_w = din_q;
            c_ch_w   = ch_onehot;
        end else if (state_q == ST_CLR) begin
            c_addr_w = clr_cnt_q;
            c_ch_w   = ch_onehot;
        end
    end

    assign bus.c_sto   = (state_q == ST_STO);
    assign bus.c_clr   = (state_q == ST_CLR);
    assign bus.busy    = (state_q != ST_IDLE);
    assign bus.cmd_err = cmd_err_q;
    assign bus.run_en  = run_en_q;
    assign bus.c_addr  = c_addr_w;
    assign bus.c_data  = c_data_w;
    assign bus.c_ch    = c_ch_w;

endmodule

// File: doc/fir_coeff_seq.md
FIR_COEFF_SEQ -- requirements
Module: fir_coeff_seq

Interface
REQ-001 SHALL have parameter NCH, default 4, number of filter channels (>=1).
REQ-002 SHALL have parameter NTAPS, default 16, coefficient slots per channel (>=2).
REQ-003 SHALL have parameter DW, default 16, coefficient data width.
REQ-004 SHALL derive AW = max(1, clog2(NTAPS)) and CHW = max(1, clog2(NCH)).
REQ-005 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port we_in  input  1  command strobe, one cycle per command.
REQ-008 SHALL have port opcode  input  4  command code, sampled with we_in.
REQ-009 SHALL have port ch_in  input  CHW  target channel, sampled with we_in.
REQ-010 SHALL have port din  input  DW  coefficient value, sampled with we_in.
REQ-011 SHALL have port c_sto  output  1  coefficient store strobe.
REQ-012 SHALL have port c_clr  output  1  coefficient clear strobe, one per tap address.
REQ-013 SHALL have port c_addr  output  AW  tap address for c_sto/c_clr.
REQ-014 SHALL have port c_data  output  DW  coefficient for c_sto.
REQ-015 SHALL have port c_ch  output  NCH  one-hot channel select for c_sto/c_clr.
REQ-016 SHALL have port run_en  output  NCH  per-channel filtering enable.
REQ-017 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.
REQ-018 SHALL have port cmd_err  output  1  one-cycle pulse on a rejected command.

Function
REQ-019 SHALL decode these opcodes: 0000 STOP, 0001 START, 0010 RST_PTR, 0100 SET_COEFF, 1000 CLR_ALL; every other code is invalid.
REQ-020 SHALL implement FSM states IDLE, DECODE, STO, CLR.
REQ-021 FSM transitions SHALL be:
- IDLE->DECODE on we_in.
- DECODE->STO on SET_COEFF.
- DECODE->CLR on CLR_ALL.
- DECODE->IDLE on all other opcodes.
- STO->IDLE unconditionally.
- CLR->IDLE after NTAPS cycles in CLR.
REQ-022 SHALL capture opcode, ch_in and din only when we_in is high in IDLE; the captured values stay stable until the FSM returns to IDLE.
REQ-023 SHALL drop we_in when busy=1 and pulse cmd_err in the following cycle; FSM state and per-channel state are unaffected.
REQ-024 SHALL treat a captured ch_in >= NCH, or an invalid opcode, as rejected: DECODE->IDLE, cmd_err pulses the cycle after DECODE, and nothing else changes.
REQ-025 SHALL keep a per-channel tap pointer ptr[ch] of AW bits.
REQ-026 SET_COEFF with we_in at cycle t SHALL assert c_sto for exactly cycle t+2, with c_addr=ptr[ch], c_data=captured din and c_ch=onehot(ch).
REQ-027 At the end of the STO cycle, SET_COEFF SHALL advance ptr[ch] by 1, wrapping from NTAPS-1 to 0 (non-power-of-2 NTAPS included).
REQ-028 CLR_ALL with we_in at cycle t SHALL assert c_clr and c_ch=onehot(ch) for cycles t+2 .. t+1+NTAPS.
REQ-029 During CLR_ALL, c_addr SHALL step 0,1,..,NTAPS-1, one address per cycle.
REQ-030 CLR_ALL SHALL set ptr[ch]=0 when it completes; run_en is unchanged.
REQ-031 START, STOP and RST_PTR SHALL update run_en[ch] (START sets, STOP clears) or ptr[ch] (RST_PTR zeroes) at the end of DECODE, visible from cycle t+2.
REQ-032 busy SHALL be low at t+2 for START/STOP/RST_PTR, at t+3 for SET_COEFF and at t+2+NTAPS for CLR_ALL; a we_in in that cycle SHALL be accepted.
REQ-033 c_sto, c_clr and busy SHALL be Moore outputs of the FSM state; c_sto and c_clr SHALL never be high together.
REQ-034 c_addr, c_data and c_ch SHALL be all-zero whenever c_sto and c_clr are both low.
REQ-035 Channels SHALL be independent: a command to channel a never alters ptr or run_en of any channel other than a.

Reset
REQ-036 rst high at a clock edge SHALL force:
- FSM to IDLE.
- all ptr[] = 0.
- run_en = 0.
- c_sto = c_clr = busy = cmd_err = 0.
- c_addr, c_data, c_ch = 0.
REQ-037 rst SHALL override any operation in progress, including mid-CLR; no further c_clr is issued after the reset edge.
REQ-038 rst SHALL take priority over a simultaneous we_in; that command is lost and cmd_err is not pulsed.

Verification
REQ-039 Setup: NCH=4, NTAPS=5, DW=16; three SET_COEFF to ch 2 with din 0x1111, 0x2222, 0x3333 -> c_sto pulses with (addr,data) = (0,0x1111), (1,0x2222), (2,0x3333), and c_ch=0100.
REQ-040 Six SET_COEFF to ch 1 -> c_addr sequence 0,1,2,3,4,0 (wrap); ptr of channels 0, 2 and 3 untouched.
REQ-041 CLR_ALL to ch 3 -> c_clr high for 5 consecutive cycles with c_addr 0..4 and c_ch=1000; a we_in during that window produces a cmd_err pulse only; busy falls at t+7.
REQ-042 START ch 0, START ch 3, STOP ch 0 -> run_en = 0001, then 1001, then 1000, each visible at t+2.
REQ-043 Rejects: opcode 0011 -> cmd_err at t+2 only; ch_in=5 with NCH=4 (CHW=2 cannot express 5, so rerun with NCH=5) -> cmd_err with no state change.
REQ-044 rst asserted in the 3rd CLR cycle -> next cycle c_clr=0, busy=0, run_en=0 and all ptr = 0.
